seg7_serial_scan: RTL and testbench

//  Parametrised multiplexed 7-segment driver for the shift-register (595-type) display path.

---
 rtl/seg7_serial_scan_if.sv | 34 +++
 rtl/seg7_serial_scan.sv | 210 +++++++++++++++++++++
 tb/tb_seg7_serial_scan.sv | 251 +++++++++++++++++++++++++
 3 files changed

// File: rtl/seg7_serial_scan_if.sv
// Display-side bundle for seg7_serial_scan: scan control and segment data in,
// 595-style serial bus and digit enables out.
// Optional: SEG7_BRIGHTNESS_EN adds the 4-bit bright input.
interface seg7_serial_scan_if #(
  parameter int DIGITS   = 2,
  parameter int SEG_BITS = 8
);
  logic                       run;
  logic [DIGITS*SEG_BITS-1:0] seg_data;
`ifdef SEG7_BRIGHTNESS_EN
  logic [3:0]                 bright;
`endif
  logic                       seg_si;
  logic                       seg_sck;
  logic                       seg_rck;
  logic [DIGITS-1:0]          seg_en;
  logic                       frame_done;

`ifdef SEG7_BRIGHTNESS_EN
  // scanner side
  modport master (input run, seg_data, bright,
                  output seg_si, seg_sck, seg_rck, seg_en, frame_done);
  // controller / display side
  modport slave  (output run, seg_data, bright,
                  input seg_si, seg_sck, seg_rck, seg_en, frame_done);
`else
  // scanner side
  modport master (input run, seg_data,
                  output seg_si, seg_sck, seg_rck, seg_en, frame_done);
  // controller / display side
  modport slave  (output run, seg_data,
                  input seg_si, seg_sck, seg_rck, seg_en, frame_done);
`endif
endinterface

// File: rtl/seg7_serial_scan.sv
// Multiplexed 7-segment scanner for a 595-type shift-register display path.
// Each digit: BLANK (all dark) -> SHIFT (MSB first on si/sck) -> LATCH (rck)
// -> HOLD (digit enable lit) -> next digit, round-robin.
// Optional: SEG7_BRIGHTNESS_EN gates the enable inside HOLD by a 4-bit duty.
module seg7_serial_scan #(
  parameter int DIGITS    = 2,
  parameter int SEG_BITS  = 8,
  parameter int CLK_DIV   = 4,
  parameter int BLANK_CYC = 16,
  parameter int HOLD_CYC  = 50000
) (
  input  logic                 clock,
  input  logic                 reset_n,
  seg7_serial_scan_if.master   bus
);

  localparam int BW = (BLANK_CYC > 1) ? $clog2(BLANK_CYC) : 1;
  localparam int DW = (CLK_DIV   > 1) ? $clog2(CLK_DIV)   : 1;
  localparam int NW = (SEG_BITS  > 1) ? $clog2(SEG_BITS)  : 1;
  localparam int HW = (HOLD_CYC  > 1) ? $clog2(HOLD_CYC)  : 1;
  localparam int GW = (DIGITS    > 1) ? $clog2(DIGITS)    : 1;

  localparam logic [BW-1:0] BLANK_LAST = BW'(BLANK_CYC - 1);
  localparam logic [DW-1:0] DIV_LAST   = DW'(CLK_DIV - 1);
  localparam logic [NW-1:0] BIT_LAST   = NW'(SEG_BITS - 1);
  localparam logic [HW-1:0] HOLD_LAST  = HW'(HOLD_CYC - 1);
  localparam logic [GW-1:0] DIGIT_LAST = GW'(DIGITS - 1);

  typedef enum logic [1:0] {
    ST_BLANK,
    ST_SHIFT,
    ST_LATCH,
    ST_HOLD
  } state_t;

  state_t              state,     state_nx;
  logic [GW-1:0]       digit,     digit_nx;
  logic [BW-1:0]       blank_cnt, blank_nx;
  logic [DW-1:0]       div_cnt,   div_nx;
  logic [NW-1:0]       bit_cnt,   bit_nx;
  logic                phase,     phase_nx;   // current sck level during SHIFT
  logic [SEG_BITS-1:0] shreg,     shreg_nx;
  logic [HW-1:0]       hold_cnt,  hold_nx;

`ifdef SEG7_BRIGHTNESS_EN
  // Number of lit HOLD cycles, fixed for the whole HOLD once sampled.
  localparam int LW = HW + 1;
  logic [LW-1:0]       hold_lim,  hold_lim_nx;
`endif

  // Output flops; loaded from the next-state view so they line up with state.
  logic                si_q,   si_nx;
  logic                sck_q,  sck_nx;
  logic                rck_q,  rck_nx;
  logic [DIGITS-1:0]   en_q,   en_nx;
  logic                fd_q,   fd_nx;

  // State, counters and shift register.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state     <= ST_BLANK;
      digit     <= '0;
      blank_cnt <= '0;
      div_cnt   <= '0;
      bit_cnt   <= '0;
      phase     <= 1'b0;
      shreg     <= '0;
      hold_cnt  <= '0;
`ifdef SEG7_BRIGHTNESS_EN
      hold_lim  <= '0;
`endif
    end else begin
      state     <= state_nx;
      digit     <= digit_nx;
      blank_cnt <= blank_nx;
      div_cnt   <= div_nx;
      bit_cnt   <= bit_nx;
      phase     <= phase_nx;
      shreg     <= shreg_nx;
      hold_cnt  <= hold_nx;
`ifdef SEG7_BRIGHTNESS_EN
      hold_lim  <= hold_lim_nx;
`endif
    end
  end

  // Next-state, counter sequencing and next output values.
  always_comb begin
    state_nx = state;
    digit_nx = digit;
    blank_nx = blank_cnt;
    div_nx   = div_cnt;
    bit_nx   = bit_cnt;
    phase_nx = phase;
    shreg_nx = shreg;
    hold_nx  = hold_cnt;
`ifdef SEG7_BRIGHTNESS_EN
    hold_lim_nx = hold_lim;
`endif

    case (state)
      ST_BLANK: begin
        if (blank_cnt == BLANK_LAST) begin
          // With run low the blank window simply repeats, keeping the digit.
          blank_nx = '0;
          if (bus.run) begin
            // Snapshot here so later seg_data edits cannot tear this digit.
            shreg_nx = bus.seg_data[int'(digit)*SEG_BITS +: SEG_BITS];
            div_nx   = '0;
            bit_nx   = '0;
            phase_nx = 1'b0;
            state_nx = ST_SHIFT;
          end
        end else begin
          blank_nx = blank_cnt + 1'b1;
        end
      end

      ST_SHIFT: begin
        if (div_cnt == DIV_LAST) begin
          div_nx = '0;
          if (!phase) begin
            phase_nx = 1'b1;
          end else begin
            // Falling sck: next bit is presented while sck is low.
            phase_nx = 1'b0;
            shreg_nx = shreg << 1;
            if (bit_cnt == BIT_LAST) begin
              state_nx = ST_LATCH;
            end else begin
              bit_nx = bit_cnt + 1'b1;
            end
          end
        end else begin
          div_nx = div_cnt + 1'b1;
        end
      end

      ST_LATCH: begin
        if (div_cnt == DIV_LAST) begin
          div_nx   = '0;
          hold_nx  = '0;
          state_nx = ST_HOLD;
`ifdef SEG7_BRIGHTNESS_EN
          hold_lim_nx = LW'(((int'(bus.bright) + 1) * HOLD_CYC) / 16);
`endif
        end else begin
          div_nx = div_cnt + 1'b1;
        end
      end

      ST_HOLD: begin
        if (hold_cnt == HOLD_LAST) begin
          hold_nx  = '0;
          blank_nx = '0;
          digit_nx = (digit == DIGIT_LAST) ? '0 : digit + 1'b1;
          state_nx = ST_BLANK;
        end else begin
          hold_nx = hold_cnt + 1'b1;
        end
      end

      default: begin
        state_nx = ST_BLANK;
        digit_nx = '0;
        blank_nx = '0;
      end
    endcase

    // Outputs as they must appear while the machine sits in state_nx.
    si_nx  = (state_nx == ST_SHIFT) ? shreg_nx[SEG_BITS-1] : 1'b0;
    sck_nx = (state_nx == ST_SHIFT) && phase_nx;
    rck_nx = (state_nx == ST_LATCH);
    en_nx  = '0;
`ifdef SEG7_BRIGHTNESS_EN
    if ((state_nx == ST_HOLD) && ({1'b0, hold_nx} < hold_lim_nx))
      en_nx = DIGITS'(1) << digit_nx;
`else
    if (state_nx == ST_HOLD)
      en_nx = DIGITS'(1) << digit_nx;
`endif
    // Pulse during the final HOLD cycle of the last digit.
    fd_nx = (state_nx == ST_HOLD) && (hold_nx == HOLD_LAST) &&
            (digit_nx == DIGIT_LAST);
  end

  // Registered outputs; reset clears them immediately.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      si_q  <= 1'b0;
      sck_q <= 1'b0;
      rck_q <= 1'b0;
      en_q  <= '0;
      fd_q  <= 1'b0;
    end else begin
      si_q  <= si_nx;
      sck_q <= sck_nx;
      rck_q <= rck_nx;
      en_q  <= en_nx;
      fd_q  <= fd_nx;
    end
  end

  assign bus.seg_si     = si_q;
  assign bus.seg_sck    = sck_q;
  assign bus.seg_rck    = rck_q;
  assign bus.seg_en     = en_q;
  assign bus.frame_done = fd_q;

endmodule

// File: tb/tb_seg7_serial_scan.sv
// Bench for seg7_serial_scan: arithmetic per-cycle reference model, a 595
// shift/latch model on the serial bus, a vector table and hand sequences.
// Build with SEG7_BRIGHTNESS_EN defined to exercise the brightness duty.
module tb_seg7_serial_scan;
  localparam int DIGITS    = 2;
  localparam int SEG_BITS  = 8;
  localparam int CLK_DIV   = 2;
  localparam int BLANK_CYC = 2;
  localparam int HOLD_CYC  = 20;
  localparam int SH_END    = BLANK_CYC + 2*SEG_BITS*CLK_DIV;   // first LATCH offset
  localparam int HOLD_BEG  = SH_END + CLK_DIV;
  localparam int PER       = HOLD_BEG + HOLD_CYC;              // 56
  localparam int FRAME     = DIGITS * PER;                     // 112

  logic clock   = 1'b0;
  logic reset_n = 1'b0;

  seg7_serial_scan_if #(.DIGITS(DIGITS), .SEG_BITS(SEG_BITS)) bus ();

  seg7_serial_scan #(
    .DIGITS(DIGITS), .SEG_BITS(SEG_BITS), .CLK_DIV(CLK_DIV),
    .BLANK_CYC(BLANK_CYC), .HOLD_CYC(HOLD_CYC)
  ) dut (
    .clock  (clock),
    .reset_n(reset_n),
    .bus    (bus)
  );

  always #5 clock = ~clock;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      if (errors <= 40) $display("FAIL %s actual=%0h required=%0h t=%0t", name, act, exp, $time);
    end
  endtask

  // Shared between stimulus and monitor.
  bit                  model_on = 1'b0;
  int                  bright_v = 15;
  logic [SEG_BITS-1:0] cap_q[$];

  // Monitor: protocol rules, 595 bus model and the cycle-level reference.
  initial begin
    int cyc, d, off, k, h, lim;
    logic [SEG_BITS-1:0] snap [DIGITS];
    logic [SEG_BITS-1:0] sr;
    logic p_sck, p_rck, p_si;
    logic e_si, e_sck, e_rck, e_fd;
    logic [DIGITS-1:0] e_en;
    cyc = 0; sr = '0; p_sck = 0; p_rck = 0; p_si = 0;
    for (int i = 0; i < DIGITS; i++) snap[i] = '0;
    forever begin
      @(negedge clock);
      if (!reset_n) begin
        cyc = 0; sr = '0; p_sck = 0; p_rck = 0; p_si = 0;
      end else begin
        chk("onehot0_en", 32'($onehot0(bus.seg_en)), 1);
        chk("en_with_clk", 32'((bus.seg_en != '0) && (bus.seg_sck || bus.seg_rck)), 0);
        if (p_sck && bus.seg_sck) chk("si_stable", bus.seg_si, p_si);
        if (!p_sck && bus.seg_sck) sr = {sr[SEG_BITS-2:0], bus.seg_si};

        d   = (cyc / PER) % DIGITS;
        off = cyc % PER;
        if (model_on) begin
          // seg_data seen now is what the DUT samples at the end of BLANK.
          if (off == BLANK_CYC-1) snap[d] = bus.seg_data[d*SEG_BITS +: SEG_BITS];
          e_si = 0; e_sck = 0; e_rck = 0; e_en = '0;
          if (off >= BLANK_CYC && off < SH_END) begin
            k     = off - BLANK_CYC;
            e_sck = ((k / CLK_DIV) % 2) == 1;
            e_si  = snap[d][SEG_BITS-1 - k/(2*CLK_DIV)];
          end else if (off >= SH_END && off < HOLD_BEG) begin
            e_rck = 1;
          end else if (off >= HOLD_BEG) begin
            h   = off - HOLD_BEG;
            lim = ((bright_v + 1) * HOLD_CYC) / 16;
            if (h < lim) e_en = DIGITS'(1 << d);
          end
          e_fd = (off == PER-1) && (d == DIGITS-1);
          chk("cycle_model", {bus.seg_si, bus.seg_sck, bus.seg_rck, bus.seg_en, bus.frame_done},
                             {e_si, e_sck, e_rck, e_en, e_fd});
        end
        if (!p_rck && bus.seg_rck) begin
          cap_q.push_back(sr);
          if (model_on) chk("latched_byte", sr, snap[d]);
        end
        p_sck = bus.seg_sck; p_rck = bus.seg_rck; p_si = bus.seg_si;
        cyc++;
      end
    end
  end

  // Reset is released #1 after a clock edge; that cycle is cycle 0.
  task automatic do_reset(input logic [DIGITS*SEG_BITS-1:0] data, input int br);
    @(posedge clock); #1;
    reset_n  = 1'b0;
    model_on = 1'b0;
    @(posedge clock); #1;
    bus.seg_data = data;
    bus.run      = 1'b1;
    bright_v     = br;
`ifdef SEG7_BRIGHTNESS_EN
    bus.bright   = 4'(br);
`endif
    cap_q.delete();
    reset_n  = 1'b1;
    model_on = 1'b1;
  endtask

  task automatic cycles(input int n);
    repeat (n) begin @(posedge clock); #1; end
  endtask

  // Lit cycles of digit 0 across its first period after a reset.
  task automatic count_en(input int br, input int expect_n);
    int n;
    n = 0;
    do_reset(16'hA53C, br);
    for (int c = 0; c < PER; c++) begin
      if (bus.seg_en[0]) n++;
      cycles(1);
    end
    chk("lit_cycles", n, expect_n);
  endtask

  typedef struct {
    logic [15:0] data;
    logic [7:0]  b0;
    logic [7:0]  b1;
  } vec_t;

  initial begin
    vec_t tbl [5];
    int   first, bad, br;

    tbl[0] = '{16'hA53C, 8'h3C, 8'hA5};
    tbl[1] = '{16'h0000, 8'h00, 8'h00};
    tbl[2] = '{16'hFFFF, 8'hFF, 8'hFF};
    tbl[3] = '{16'h8001, 8'h01, 8'h80};
    tbl[4] = '{16'h1234, 8'h34, 8'h12};

    bus.run      = 1'b0;
    bus.seg_data = '0;
`ifdef SEG7_BRIGHTNESS_EN
    bus.bright   = 4'd15;
`endif

    // Reset state.
    repeat (3) @(posedge clock);
    #1;
    chk("reset_state", {bus.seg_si, bus.seg_sck, bus.seg_rck, bus.seg_en, bus.frame_done}, 0);

    // Vector table: one frame each, bytes seen by the 595 model.
    for (int i = 0; i < 5; i++) begin
      do_reset(tbl[i].data, 15);
      cycles(FRAME);
      chk("tbl_latch_count", cap_q.size(), 2);
      if (cap_q.size() >= 2) begin
        chk("tbl_byte0", cap_q[0], tbl[i].b0);
        chk("tbl_byte1", cap_q[1], tbl[i].b1);
      end
    end

    // Reset in the middle of SHIFT clears outputs without a clock edge.
    do_reset(16'hFFFF, 15);
    cycles(12);
    chk("pre_reset_sck", bus.seg_sck, 1);
    #2;
    reset_n  = 1'b0;
    model_on = 1'b0;
    #1;
    chk("async_clear", {bus.seg_si, bus.seg_sck, bus.seg_rck, bus.seg_en, bus.frame_done}, 0);
    @(posedge clock); #1;
    reset_n  = 1'b1;
    model_on = 1'b1;
    first = -1;
    for (int c = 0; c < 10; c++) begin
      if (bus.seg_sck && first < 0) first = c;
      cycles(1);
    end
    chk("first_sck_rise", first, 4);
    cycles(FRAME);

    // Data change mid-SHIFT of digit 0 must not reach the shifted byte.
    do_reset(16'h5AC3, 15);
    cycles(10);
    bus.seg_data = 16'h0000;
    for (int c = 0; c < 100 && cap_q.size() == 0; c++) cycles(1);
    chk("no_tear_seen", cap_q.size() > 0, 1);
    if (cap_q.size() > 0) chk("no_tear_byte", cap_q[0], 8'hC3);

    // run dropped in digit 0 HOLD: digit finishes, then dark; resume at digit 1.
    do_reset(16'hA53C, 15);
    cycles(40);
    model_on = 1'b0;
    bus.run  = 1'b0;
    bad = 0;
    for (int c = 40; c < PER; c++) begin
      if (bus.seg_en != 2'b01) bad++;
      cycles(1);
    end
    chk("stop_completes_hold", bad, 0);
    bad = 0;
    for (int c = 0; c < 80; c++) begin
      if (bus.seg_en != '0 || bus.seg_sck || bus.seg_rck) bad++;
      cycles(1);
    end
    chk("stopped_dark", bad, 0);
    chk("stopped_no_latch", cap_q.size(), 1);
    cap_q.delete();
    bus.run = 1'b1;
    for (int c = 0; c < 200 && cap_q.size() == 0; c++) cycles(1);
    chk("resume_seen", cap_q.size() > 0, 1);
    if (cap_q.size() > 0) chk("resume_byte", cap_q[0], 8'hA5);
    bad = 1;
    for (int c = 0; c < 50 && bad != 0; c++) begin
      if (bus.seg_en != '0) bad = 0; else cycles(1);
    end
    chk("resume_en", bus.seg_en, 2'b10);

    // Lit duty of HOLD.
`ifdef SEG7_BRIGHTNESS_EN
    count_en(3, 5);
    count_en(15, 20);
    count_en(0, 1);
`else
    count_en(15, 20);
`endif

    // Randomised run over 10 frames with sporadic seg_data edits.
`ifdef SEG7_BRIGHTNESS_EN
    br = int'($urandom_range(0, 15));
`else
    br = 15;
`endif
    do_reset(16'($urandom), br);
    for (int c = 0; c < 10*FRAME; c++) begin
      if ($urandom_range(0, 7) == 0) bus.seg_data = 16'($urandom);
      cycles(1);
    end
    chk("random_latch_count", cap_q.size(), 2*10);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
